// File: rtl/ila_pkg.sv
// rtl/ila_pkg.sv - shared state encoding and constants for the ILA read path
package ila_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ADDR,
      ST_WAIT,
      ST_SEND
   } ila_rd_state_t;

   localparam int ILA_READ_LAT = 2;

   // Number of data-width slices needed to carry one captured sample.
   function automatic int ila_slices(input int sig_w, input int data_w);
      return (sig_w + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/ila_read_wait_cnt.sv
// rtl/ila_read_wait_cnt.sv - loadable down-counter with zero flag for read latency
module ila_read_wait_cnt #(
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cke,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (cke) begin
         if (load) begin
            cnt <= load_value;
         end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
         end
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ila_buffer_reader.sv
// rtl/ila_buffer_reader.sv - walks the ILA sample buffer and streams every slice
module ila_buffer_reader
   import ila_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int BUFFER_W         = 10,
   parameter int SEL_W            = 2,
   parameter int WORDS_PER_SAMPLE = ila_slices(32, 32),
   parameter int READ_LAT         = ILA_READ_LAT,
   parameter int HEADER_EN        = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cke_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [BUFFER_W-1:0] samples_i,
   output logic [BUFFER_W-1:0] index_o,
   output logic [SEL_W-1:0]    value_select_o,
   input  logic [DATA_W-1:0]   value_i,
   output logic [DATA_W-1:0]   data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                last_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int CNT_W = $clog2(READ_LAT + 1);
   localparam logic [CNT_W-1:0] LAT    = CNT_W'(READ_LAT);
   localparam logic [SEL_W-1:0] W_LAST = SEL_W'(WORDS_PER_SAMPLE - 1);

   ila_rd_state_t       state, nxt;
   logic [BUFFER_W-1:0] n, s, idx;
   logic [SEL_W-1:0]    w, sel;
   logic [DATA_W-1:0]   data_q;
   logic                done_q;
   logic                cnt_load, cnt_dec, cnt_zero;
   logic                last_word;

   ila_read_wait_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cke        (cke_i),
      .load       (cnt_load),
      .load_value (LAT),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   assign last_word = (s == n - BUFFER_W'(1)) && (w == W_LAST);

   always_comb begin
      nxt      = state;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      valid_o  = 1'b0;
      last_o   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               if (HEADER_EN != 0)          nxt = ST_HDR;
               else if (samples_i != '0)    nxt = ST_ADDR;
            end
         end
         ST_HDR: begin
            valid_o = 1'b1;
            last_o  = (n == '0);
            if (ready_i) nxt = (n == '0) ? ST_IDLE : ST_ADDR;
         end
         ST_ADDR: begin
            cnt_load = 1'b1;
            nxt      = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_zero) nxt = ST_SEND;
            else          cnt_dec = 1'b1;
         end
         ST_SEND: begin
            valid_o = 1'b1;
            last_o  = last_word;
            if (ready_i) nxt = last_word ? ST_IDLE : ST_ADDR;
         end
         default: nxt = ST_IDLE;
      endcase
      // Abort beats any handshake and leaves the index where it was.
      if (abort_i && state != ST_IDLE) begin
         nxt      = ST_IDLE;
         cnt_load = 1'b0;
         cnt_dec  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= ST_IDLE;
         n      <= '0;
         s      <= '0;
         w      <= '0;
         idx    <= '0;
         sel    <= '0;
         data_q <= '0;
         done_q <= 1'b0;
      end else if (cke_i) begin
         state  <= nxt;
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start_i && !abort_i) begin
                  n      <= samples_i;
                  s      <= '0;
                  w      <= '0;
                  idx    <= '0;
                  sel    <= '0;
                  data_q <= DATA_W'(samples_i);
                  if (HEADER_EN == 0 && samples_i == '0) done_q <= 1'b1;
               end
            end
            ST_HDR: begin
               if (ready_i && !abort_i && n == '0) done_q <= 1'b1;
            end
            ST_ADDR: begin
               if (!abort_i) begin
                  idx <= s;
                  sel <= w;
               end
            end
            ST_WAIT: begin
               if (!abort_i && cnt_zero) data_q <= value_i;
            end
            ST_SEND: begin
               if (ready_i && !abort_i) begin
                  if (last_word) begin
                     done_q <= 1'b1;
                  end else if (w == W_LAST) begin
                     w <= '0;
                     s <= s + BUFFER_W'(1);
                  end else begin
                     w <= w + SEL_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign index_o        = idx;
   assign value_select_o = sel;
   assign data_o         = data_q;
   assign busy_o         = (state != ST_IDLE);
   assign done_o         = done_q;

endmodule
